// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered reset-release sequencer; optional watchdog via RESET_SEQ_WATCHDOG_EN
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [NUM_STAGES-1:0] READY_MASK = {NUM_STAGES{1'b1}}
) (
    input  logic                  clk_a,
    input  logic                  resetn_a,
    input  logic                  soft_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic [2:0]            seq_stage,
    output logic                  seq_done,
    output logic                  seq_timeout
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("reset_sequencer: parameter out of range");
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    typedef enum logic [2:0] {ST_HOLD, ST_RELEASE, ST_WAIT, ST_DONE, ST_FAULT} state_t;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             seq_timeout_q, seq_timeout_d;
`else
    typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_WAIT, ST_DONE} state_t;
`endif

    state_t                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [NUM_STAGES-1:0]   stage_resetn_q, stage_resetn_d;
    logic [2:0]              seq_stage_q, seq_stage_d;
    logic                    seq_done_q, seq_done_d;
    logic                    cur_ok;
    logic                    cur_last;
    logic [NUM_STAGES-1:0]   cur_onehot;

    // Decode the stage currently addressed: its release bit and whether it may be passed.
    always_comb begin
        cur_ok     = 1'b0;
        cur_onehot = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (seq_stage_q == 3'(i)) begin
                cur_ok        = ~READY_MASK[i] | stage_ready[i];
                cur_onehot[i] = 1'b1;
            end
        end
        cur_last = (seq_stage_q == 3'(NUM_STAGES - 1));
    end

    // Next-state and registered-output logic; a soft request overrides every transition.
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        stage_resetn_d = stage_resetn_q;
        seq_stage_d    = seq_stage_q;
        seq_done_d     = seq_done_q;
`ifdef RESET_SEQ_WATCHDOG_EN
        tmo_cnt_d      = tmo_cnt_q;
        seq_timeout_d  = seq_timeout_q;
`endif
        if (soft_reset_req) begin
            state_d        = ST_HOLD;
            hold_cnt_d     = '0;
            stage_resetn_d = '0;
            seq_stage_d    = '0;
            seq_done_d     = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
            tmo_cnt_d      = '0;
            seq_timeout_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    stage_resetn_d = '0;
                    if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state_d     = ST_RELEASE;
                        seq_stage_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    stage_resetn_d = stage_resetn_q | cur_onehot;
`ifdef RESET_SEQ_WATCHDOG_EN
                    tmo_cnt_d      = '0;
`endif
                    state_d        = ST_WAIT;
                end
                ST_WAIT: begin
                    if (cur_ok) begin
                        if (cur_last) begin
                            state_d    = ST_DONE;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d     = ST_RELEASE;
                            seq_stage_d = seq_stage_q + 3'd1;
                        end
`ifdef RESET_SEQ_WATCHDOG_EN
                    end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d        = ST_FAULT;
                        stage_resetn_d = '0;
                        seq_timeout_d  = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                    end
                end
                ST_DONE: begin
                    stage_resetn_d = '1;
                end
`ifdef RESET_SEQ_WATCHDOG_EN
                ST_FAULT: begin
                    stage_resetn_d = '0;
                end
`endif
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Sequencer state register; the asynchronous reset drops every stage reset at once.
    always_ff @(posedge clk_a or negedge resetn_a) begin
        if (!resetn_a) begin
            state_q        <= ST_HOLD;
            hold_cnt_q     <= '0;
            stage_resetn_q <= '0;
            seq_stage_q    <= '0;
            seq_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            stage_resetn_q <= stage_resetn_d;
            seq_stage_q    <= seq_stage_d;
            seq_done_q     <= seq_done_d;
        end
    end

`ifdef RESET_SEQ_WATCHDOG_EN
    // Watchdog counter and sticky fault flag.
    always_ff @(posedge clk_a or negedge resetn_a) begin
        if (!resetn_a) begin
            tmo_cnt_q     <= '0;
            seq_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            seq_timeout_q <= seq_timeout_d;
        end
    end

    assign seq_timeout = seq_timeout_q;
`else
    assign seq_timeout = 1'b0;
`endif

    assign stage_resetn = stage_resetn_q;
    assign seq_stage    = seq_stage_q;
    assign seq_done     = seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer against an event-time model
module tb_reset_sequencer;

    localparam int HOLD = 16;
    localparam int TMO  = 1024;
`ifdef RESET_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk_a = 1'b0;
    logic       resetn_a = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic [3:0] stage_ready = 4'b1111;

    logic [3:0] sr0, sr1;
    logic [2:0] st0, st1;
    logic       dn0, dn1, to0, to1;

    int tests = 0;
    int fails = 0;

    always #5 clk_a = ~clk_a;

    reset_sequencer u_dut0 (
        .clk_a(clk_a), .resetn_a(resetn_a), .soft_reset_req(soft_reset_req),
        .stage_ready(stage_ready), .stage_resetn(sr0), .seq_stage(st0),
        .seq_done(dn0), .seq_timeout(to0)
    );

    reset_sequencer #(.READY_MASK(4'b0101)) u_dut1 (
        .clk_a(clk_a), .resetn_a(resetn_a), .soft_reset_req(soft_reset_req),
        .stage_ready(stage_ready), .stage_resetn(sr1), .seq_stage(st1),
        .seq_done(dn1), .seq_timeout(to1)
    );

    // Model: event times. A sequence start at edge c releases stage 0 at c+HOLD+1;
    // a stage found ready at edge n releases the next one at n+1.
    int cyc = 0;
    int m_nrel [2];
    int m_idx  [2];
    int m_next [2];
    int m_rel  [2];
    bit m_done [2];
    bit m_fault[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_nrel[k] = 0; m_idx[k] = 0; m_next[k] = -1; m_rel[k] = 0;
            m_done[k] = 1'b0; m_fault[k] = 1'b0;
        end
    end

    always @(posedge clk_a) begin
        logic [3:0] mk;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            mk = (k == 0) ? 4'b1111 : 4'b0101;
            if (!resetn_a || soft_reset_req) begin
                m_nrel[k] = 0; m_idx[k] = 0; m_done[k] = 1'b0; m_fault[k] = 1'b0;
                m_next[k] = cyc + HOLD + 1;
            end else if (m_done[k] || m_fault[k]) begin
                m_nrel[k] = m_nrel[k];
            end else if (cyc == m_next[k]) begin
                m_nrel[k]++;
                m_rel[k] = cyc;
            end else if (m_nrel[k] > 0) begin
                if (!mk[m_idx[k]] || stage_ready[m_idx[k]]) begin
                    if (m_idx[k] == 3) m_done[k] = 1'b1;
                    else begin
                        m_idx[k]++;
                        m_next[k] = cyc + 1;
                    end
                end else if (WD && (cyc - m_rel[k] >= TMO)) begin
                    m_fault[k] = 1'b1;
                end
            end
        end
    end

    function automatic logic [8:0] model_exp(int k);
        logic [3:0] s;
        s = m_fault[k] ? 4'b0000 : 4'((1 << m_nrel[k]) - 1);
        return {s, 3'(m_idx[k]), m_done[k], m_fault[k]};
    endfunction

    function automatic logic [8:0] dut_act(int k);
        if (k == 0) return {sr0, st0, dn0, to0};
        return {sr1, st1, dn1, to1};
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk_a) begin
        logic [8:0] e, a;
        for (int k = 0; k < 2; k++) begin
            e = resetn_a ? model_exp(k) : 9'h000;
            a = dut_act(k);
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t dut%0d {sr,stage,done,tmo} got %b want %b", $time, k, a, e);
            end
        end
    end

    // Hand-computed literal checks on the DUT and on the model.
    task automatic lit(input string name, input int k, input logic [8:0] want);
        logic [8:0] a, m;
        a = dut_act(k);
        m = resetn_a ? model_exp(k) : 9'h000;
        tests++;
        if (a !== want) begin
            fails++;
            $display("FAIL %s dut%0d got %b want %b", name, k, a, want);
        end
        tests++;
        if (m !== want) begin
            fails++;
            $display("FAIL %s model%0d got %b want %b", name, k, m, want);
        end
    endtask

    task automatic timeline(input string tag);
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk_a); #1;
            case (e)
                16: lit({tag, "_e16"}, 0, {4'b0000, 3'd0, 1'b0, 1'b0});
                17: lit({tag, "_e17"}, 0, {4'b0001, 3'd0, 1'b0, 1'b0});
                18: lit({tag, "_e18"}, 0, {4'b0001, 3'd1, 1'b0, 1'b0});
                19: lit({tag, "_e19"}, 0, {4'b0011, 3'd1, 1'b0, 1'b0});
                21: lit({tag, "_e21"}, 0, {4'b0111, 3'd2, 1'b0, 1'b0});
                23: lit({tag, "_e23"}, 0, {4'b1111, 3'd3, 1'b0, 1'b0});
                24: lit({tag, "_e24"}, 0, {4'b1111, 3'd3, 1'b1, 1'b0});
                default: ;
            endcase
        end
    endtask

    task automatic soft_pulse();
        soft_reset_req = 1'b1;
        @(posedge clk_a); #1;
        soft_reset_req = 1'b0;
    endtask

    initial begin
        // Power-on reset and first release.
        repeat (3) @(posedge clk_a);
        #1;
        lit("reset_state", 0, 9'h000);
        lit("reset_state", 1, 9'h000);
        @(negedge clk_a); #2;
        resetn_a = 1'b1;
        timeline("por");

        // Soft request from DONE repeats the same timing.
        soft_pulse();
        lit("soft_clear", 0, 9'h000);
        lit("soft_clear", 1, 9'h000);
        timeline("soft");

        // Late ready on stage 0.
        stage_ready = 4'b0000;
        soft_pulse();
        repeat (17) @(posedge clk_a);
        #1;
        lit("late_s0_rel", 0, {4'b0001, 3'd0, 1'b0, 1'b0});
        repeat (50) @(posedge clk_a);
        #1;
        stage_ready = 4'b0001;
        @(posedge clk_a); #1;
        lit("late_s0_adv", 0, {4'b0001, 3'd1, 1'b0, 1'b0});
        @(posedge clk_a); #1;
        lit("late_s1_rel", 0, {4'b0011, 3'd1, 1'b0, 1'b0});
        repeat (10) @(posedge clk_a);
        #1;
        lit("late_s1_stall", 0, {4'b0011, 3'd1, 1'b0, 1'b0});

        // Masked stages do not stall.
        stage_ready = 4'b0101;
        soft_pulse();
        repeat (24) @(posedge clk_a);
        #1;
        lit("mask_done", 1, {4'b1111, 3'd3, 1'b1, 1'b0});
        lit("mask_stall", 0, {4'b0011, 3'd1, 1'b0, 1'b0});

        // Asynchronous reset while waiting on stage 2.
        stage_ready = 4'b0011;
        soft_pulse();
        repeat (30) @(posedge clk_a);
        #1;
        lit("wait_s2", 0, {4'b0111, 3'd2, 1'b0, 1'b0});
        @(posedge clk_a); #3;
        resetn_a = 1'b0;
        #1;
        lit("async_rst", 0, 9'h000);
        lit("async_rst", 1, 9'h000);
        repeat (2) @(posedge clk_a);
        @(negedge clk_a); #2;
        stage_ready = 4'b1111;
        resetn_a = 1'b1;
        timeline("rerst");

`ifdef RESET_SEQ_WATCHDOG_EN
        // Stage 1 never ready: fault 1024 cycles after its release on edge 19.
        stage_ready = 4'b0001;
        soft_pulse();
        repeat (19 + TMO - 1) @(posedge clk_a);
        #1;
        lit("wd_before", 0, {4'b0011, 3'd1, 1'b0, 1'b0});
        @(posedge clk_a); #1;
        lit("wd_fault", 0, {4'b0000, 3'd1, 1'b0, 1'b1});
        repeat (5) @(posedge clk_a);
        #1;
        lit("wd_sticky", 0, {4'b0000, 3'd1, 1'b0, 1'b1});
        soft_pulse();
        lit("wd_clear", 0, 9'h000);
`endif

        // Randomized traffic with occasional soft requests and async resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_a); #1;
            stage_ready    = 4'($urandom);
            soft_reset_req = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 resetn_a = 1'b0;
                @(posedge clk_a);
                @(negedge clk_a); #2;
                resetn_a = 1'b1;
            end
        end
        @(posedge clk_a); #1;
        soft_reset_req = 1'b0;
        repeat (3) @(posedge clk_a);
        @(negedge clk_a); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
